// File: rtl/hazard_if.sv
// Pipeline hazard bundle: ID/EX instruction fields in, pipeline control out.
interface hazard_if;
  logic [3:0]  id_op1;
  logic [3:0]  id_op2;
  logic [3:0]  ex_op1;
  logic [1:0]  ex_regwrite;
  logic        ex_memread;
  logic        id_branch;
  logic        branch_taken;
  logic        id_muldiv;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        ifid_flush;
  logic [1:0]  hz_state;
  logic [15:0] stall_total;

  // Pipeline side: drives the instruction fields, observes control
  modport master (
    output id_op1, id_op2, ex_op1, ex_regwrite, ex_memread,
           id_branch, branch_taken, id_muldiv,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, hz_state, stall_total
  );

  // Hazard unit side
  modport slave (
    input  id_op1, id_op2, ex_op1, ex_regwrite, ex_memread,
           id_branch, branch_taken, id_muldiv,
    output pc_write, ifid_write, idex_bubble, ifid_flush, hz_state, stall_total
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection unit: load-use / branch-dependency stalls, taken-branch
// flush and multi-cycle multiply/divide occupancy of EX.
module hazard_unit #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input logic    clk,
  input logic    rst_n,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    STALL   = 2'b01,
    MD_BUSY = 2'b10
  } hz_state_e;

  // First busy-cycle count after a muldiv issues; busy lasts MULDIV_CYCLES-1 cycles
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 2);

  hz_state_e   state_r;
  hz_state_e   state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic [1:0]  hz_len_s;
  logic        stall_s;
  logic        flush_s;
  logic [15:0] stall_total_r;
  logic        match1_s;
  logic        match2_s;

  assign match1_s = (hz.ex_op1 == hz.id_op1);
  assign match2_s = (hz.ex_op1 == hz.id_op2);

  // Hazard length seen by the ID instruction, highest priority first
  always_comb begin
    hz_len_s = 2'd0;
    if (hz.id_branch && hz.ex_memread && match1_s) begin
      hz_len_s = 2'd2;
    end else if (hz.ex_memread && (match1_s || match2_s)) begin
      hz_len_s = 2'd1;
    end else if (hz.id_branch && hz.ex_regwrite[1] && match1_s) begin
      hz_len_s = 2'd1;
    end else begin
      hz_len_s = 2'd0;
    end
  end

  // Next state, counter update and raw stall/flush decisions
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (hz_len_s != 2'd0) begin
          stall_s   = 1'b1;
          cnt_nxt_s = {2'b00, hz_len_s} - 4'd1;
          if (hz_len_s > 2'd1) begin
            state_nxt_s = STALL;
          end else begin
            state_nxt_s = RUN;
          end
        end else if (hz.id_branch) begin
          // branch wins over an (illegal) simultaneous muldiv
          flush_s = hz.branch_taken;
        end else if (hz.id_muldiv) begin
          cnt_nxt_s   = MD_LOAD;
          state_nxt_s = MD_BUSY;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STALL: begin
        stall_s = 1'b1;
        if (cnt_r <= 4'd1) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = STALL;
        end
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          cnt_nxt_s = 4'd0;
        end
      end
      MD_BUSY: begin
        stall_s = 1'b1;
        if (cnt_r == 4'd0) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = MD_BUSY;
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Pipeline control outputs; reset forces a held, bubbled pipeline
  always_comb begin
    hz.pc_write    = 1'b0;
    hz.ifid_write  = 1'b0;
    hz.idex_bubble = 1'b1;
    hz.ifid_flush  = 1'b0;
    if (!rst_n) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
      hz.ifid_flush  = 1'b0;
    end else begin
      hz.pc_write    = ~stall_s;
      hz.ifid_write  = ~stall_s;
      hz.idex_bubble = stall_s;
      hz.ifid_flush  = flush_s;
    end
  end

  assign hz.hz_state    = state_r;
  assign hz.stall_total = stall_total_r;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_total_r <= 16'd0;
    end else if (stall_s && (stall_total_r != 16'hFFFF)) begin
      stall_total_r <= stall_total_r + 16'd1;
    end else begin
      stall_total_r <= stall_total_r;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: cycle-by-cycle comparison against a
// stall-budget model plus pinned hand-computed checkpoints.
module tb_hazard_unit;
  localparam int MD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hazard_if hif ();

  hazard_unit #(.MULDIV_CYCLES(MD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hif.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: m_left = stalled cycles still owed, starting with the current one
  int m_left;
  int m_kind;
  int m_total;

  // Pinned checkpoints posted by the stimulus, consumed by the compare process
  int    pin_seq = 0;
  int    seen_seq = 0;
  string pin_name;
  int    pin_total;
  int    pin_state;
  int    pin_stall;
  int    pin_flush;

  function automatic int hz_len();
    if (hif.id_branch && hif.ex_memread && hif.ex_op1 == hif.id_op1) return 2;
    if (hif.ex_memread && (hif.ex_op1 == hif.id_op1 || hif.ex_op1 == hif.id_op2)) return 1;
    if (hif.id_branch && hif.ex_regwrite[1] && hif.ex_op1 == hif.id_op1) return 1;
    return 0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Model update at each clock edge; reset clears it asynchronously
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_kind  <= 0;
      m_total <= 0;
    end else if (m_left > 0) begin
      m_total <= sat_inc(m_total);
      m_left  <= m_left - 1;
      if (m_left == 1) m_kind <= 0;
    end else if (hz_len() > 0) begin
      m_total <= sat_inc(m_total);
      m_left  <= hz_len() - 1;
      m_kind  <= (hz_len() > 1) ? 1 : 0;
    end else if (hif.id_muldiv && !hif.id_branch) begin
      m_left <= MD - 1;
      m_kind <= 2;
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Compare process: every falling edge, DUT against model and pinned values
  always @(negedge clk) begin
    int e_stall;
    int e_flush;
    int e_state;
    int e_total;
    if (!rst_n) begin
      e_stall = 1; e_flush = 0; e_state = 0; e_total = 0;
    end else if (m_left > 0) begin
      e_stall = 1; e_flush = 0; e_state = m_kind; e_total = m_total;
    end else begin
      e_stall = (hz_len() > 0) ? 1 : 0;
      e_flush = (hz_len() == 0 && hif.id_branch && hif.branch_taken) ? 1 : 0;
      e_state = 0;
      e_total = m_total;
    end
    check("pc_write",    int'(hif.pc_write),    (rst_n && !e_stall) ? 1 : 0);
    check("ifid_write",  int'(hif.ifid_write),  (rst_n && !e_stall) ? 1 : 0);
    check("idex_bubble", int'(hif.idex_bubble), e_stall);
    check("ifid_flush",  int'(hif.ifid_flush),  e_flush);
    check("hz_state",    int'(hif.hz_state),    e_state);
    check("stall_total", int'(hif.stall_total), e_total);
    if (pin_seq != seen_seq) begin
      seen_seq = pin_seq;
      check({pin_name, ".total"},       int'(hif.stall_total), pin_total);
      check({pin_name, ".model_total"}, m_total,               pin_total);
      check({pin_name, ".state"},       int'(hif.hz_state),    pin_state);
      check({pin_name, ".bubble"},      int'(hif.idex_bubble), pin_stall);
      check({pin_name, ".flush"},       int'(hif.ifid_flush),  pin_flush);
    end
  end

  task automatic pin(input string nm, input int tot, input int st, input int stl, input int fl);
    pin_name  = nm;
    pin_total = tot;
    pin_state = st;
    pin_stall = stl;
    pin_flush = fl;
    pin_seq++;
  endtask

  task automatic clr();
    hif.id_op1 = 4'd1; hif.id_op2 = 4'd2; hif.ex_op1 = 4'd15;
    hif.ex_regwrite = 2'b00; hif.ex_memread = 1'b0;
    hif.id_branch = 1'b0; hif.branch_taken = 1'b0; hif.id_muldiv = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #1;
    pin("reset", 0, 0, 1, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Load-use: one stall, stays in RUN
    hif.ex_memread = 1'b1; hif.ex_op1 = 4'd5; hif.id_op2 = 4'd5;
    pin("lu", 0, 0, 1, 0); tick();
    clr(); pin("lu_after", 1, 0, 0, 0); tick();

    // Branch on a load: two stalls, RUN then STALL
    hif.id_branch = 1'b1; hif.ex_memread = 1'b1; hif.ex_op1 = 4'd3; hif.id_op1 = 4'd3;
    pin("bl1", 1, 0, 1, 0); tick();
    clr(); pin("bl2", 2, 1, 1, 0); tick();
    pin("bl3", 3, 0, 0, 0); tick();

    // Muldiv: free issue cycle, three busy stalls ignoring new hazards/branches
    hif.id_muldiv = 1'b1;
    pin("md_issue", 3, 0, 0, 0); tick();
    hif.ex_memread = 1'b1; hif.ex_op1 = 4'd2; hif.id_op1 = 4'd2;
    hif.id_branch = 1'b1; hif.branch_taken = 1'b1; hif.id_muldiv = 1'b1;
    pin("md1", 3, 2, 1, 0); tick();
    pin("md2", 4, 2, 1, 0); tick();
    pin("md3", 5, 2, 1, 0); tick();
    clr(); pin("md_done", 6, 0, 0, 0); tick();

    // Taken branch without dependency flushes for one cycle
    hif.id_branch = 1'b1; hif.branch_taken = 1'b1; hif.id_op1 = 4'd7; hif.ex_op1 = 4'd7;
    pin("br_flush", 6, 0, 0, 1); tick();
    clr(); pin("br_after", 6, 0, 0, 0); tick();
    // Same branch depending on an ALU result: stall, no flush
    hif.id_branch = 1'b1; hif.branch_taken = 1'b1; hif.ex_regwrite = 2'b10;
    hif.id_op1 = 4'd7; hif.ex_op1 = 4'd7;
    pin("br_haz", 6, 0, 1, 0); tick();
    // Write-enable bit 1 clear: no dependency, flush
    hif.ex_regwrite = 2'b01;
    pin("br_we01", 7, 0, 0, 1); tick();
    clr(); tick();

    // Muldiv behind a load-use hazard: hazard first, then issue
    hif.id_muldiv = 1'b1; hif.ex_memread = 1'b1; hif.ex_op1 = 4'd4; hif.id_op2 = 4'd4;
    pin("mh_haz", 7, 0, 1, 0); tick();
    hif.ex_memread = 1'b0;
    pin("mh_issue", 8, 0, 0, 0); tick();
    clr(); pin("mh_busy", 8, 2, 1, 0); tick();
    tick(); tick();
    pin("mh_done", 11, 0, 0, 0); tick();

    // Branch with muldiv: branch wins, no busy period
    hif.id_branch = 1'b1; hif.branch_taken = 1'b1; hif.id_muldiv = 1'b1;
    pin("br_md", 11, 0, 0, 1); tick();
    clr(); pin("br_md_after", 11, 0, 0, 0); tick();

    // Register 0 participates in comparisons
    hif.ex_memread = 1'b1; hif.ex_op1 = 4'd0; hif.id_op1 = 4'd0; hif.id_op2 = 4'd9;
    pin("r0", 11, 0, 1, 0); tick();
    clr(); tick();

    // Reset in MD_BUSY after one stall cycle aborts at once
    hif.id_muldiv = 1'b1; tick();
    clr(); pin("rm_busy", 12, 2, 1, 0); tick();
    rst_n = 1'b0;
    #1;
    pin("rm_reset", 0, 0, 1, 0);
    tick();
    rst_n = 1'b1;
    tick();
    hif.ex_memread = 1'b1; hif.ex_op1 = 4'd5; hif.id_op2 = 4'd5;
    pin("rm_lu", 0, 0, 1, 0); tick();
    clr(); pin("rm_lu_after", 1, 0, 0, 0); tick();

    // Saturation: continuous load-use stalls past 65535
    hif.ex_memread = 1'b1; hif.ex_op1 = 4'd6; hif.id_op1 = 4'd6;
    repeat (65540) tick();
    pin("sat", 65535, 0, 1, 0); tick();
    clr(); pin("sat_hold", 65535, 0, 0, 0); tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
